// File: rtl/apb_master.sv
// APB requester: turns one command/response handshake into a single APB transfer,
// with an optional abort when the completer holds PREADY low for too long.
//
// state  | meaning
// IDLE   | no transfer; cmd_ready high, APB address/data hold last values
// SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
// ACCESS | PSEL=1, PENABLE=1 until PREADY or wait-count abort
// RESP   | rsp_valid=1, result held until rsp_ready
module apb_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam int TMO_BITS = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W    = (TMO_BITS > 16) ? TMO_BITS : 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_inc;
   logic             tmo_hit;

   assign cmd_ready = (state == IDLE) && !PRESET;

   // Saturating increment; the threshold test looks at the count this wait cycle produces.
   always_comb begin
      wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
      tmo_hit      = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= IDLE;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_timeout <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               if (cmd_valid && cmd_ready) begin
                  PADDR  <= cmd_addr;
                  PWRITE <= cmd_write;
                  PWDATA <= cmd_wdata;
                  PSEL   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               PENABLE  <= 1'b1;
               wait_cnt <= '0;
               state    <= ACCESS;
            end
            ACCESS: begin
               // PREADY wins over a timeout reached in the same cycle.
               if (PREADY) begin
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= RESP;
               end else if (tmo_hit) begin
                  rsp_rdata   <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  wait_cnt    <= wait_cnt_inc;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt_inc;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: transaction-level reference model checked every cycle,
// plus hand-computed expectations for the key transfer shapes.
module tb_apb_master;

   localparam int TMO = 4;

   logic        PCLK;
   logic        PRESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_timeout;
   logic [31:0] PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   int n_assert = 0;
   int n_fail   = 0;

   apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transfer is "busy" from acceptance until its result is known;
   // m_age 0 is the setup cycle, m_age k>=1 is the k-th access (wait) cycle.
   bit          m_busy = 0;
   bit          m_resp = 0;
   int          m_age  = 0;
   logic [31:0] e_paddr  = '0;
   logic        e_pwrite = 1'b0;
   logic [31:0] e_pwdata = '0;
   logic [31:0] e_rdata  = '0;
   logic        e_tmo    = 1'b0;

   always @(posedge PCLK) begin
      if (PRESET) begin
         m_busy = 0; m_resp = 0; m_age = 0;
         e_paddr = '0; e_pwrite = 1'b0; e_pwdata = '0; e_rdata = '0; e_tmo = 1'b0;
      end else if (m_resp) begin
         if (rsp_ready) m_resp = 0;
      end else if (m_busy) begin
         if (m_age == 0) m_age = 1;
         else if (PREADY) begin
            m_busy = 0; m_resp = 1; e_tmo = 1'b0;
            e_rdata = e_pwrite ? 32'h0 : PRDATA;
         end else if (TMO != 0 && m_age >= TMO) begin
            m_busy = 0; m_resp = 1; e_tmo = 1'b1; e_rdata = 32'h0;
         end else m_age++;
      end else if (cmd_valid) begin
         m_busy = 1; m_age = 0;
         e_paddr = cmd_addr; e_pwrite = cmd_write; e_pwdata = cmd_wdata;
      end
   end

   always @(posedge PCLK) begin
      #4;
      chk("m_psel",      PSEL,        m_busy);
      chk("m_penable",   PENABLE,     m_busy && m_age >= 1);
      chk("m_rsp_valid", rsp_valid,   m_resp);
      chk("m_cmd_ready", cmd_ready,   !m_busy && !m_resp && !PRESET);
      chk("m_paddr",     PADDR,       e_paddr);
      chk("m_pwrite",    PWRITE,      e_pwrite);
      chk("m_pwdata",    PWDATA,      e_pwdata);
      chk("m_rsp_rdata", rsp_rdata,   e_rdata);
      chk("m_rsp_tmo",   rsp_timeout, e_tmo);
   end

   // Called at a negedge while idle; returns at the negedge of the setup cycle.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      @(negedge PCLK);
      cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'h1357_9BDF;
   endtask

   // nwait < 0: never ready. Returns at the negedge of the first response cycle.
   task automatic wait_resp(input int nwait, input logic [31:0] prd, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int acc, output logic tmo, output logic [31:0] rd);
      bit done;
      done = 0; acc = 0; tmo = 1'bx; rd = 'x;
      for (int g = 0; g < 40 && !done; g++) begin
         @(negedge PCLK);
         if (rsp_valid) begin
            done = 1; tmo = rsp_timeout; rd = rsp_rdata;
            chk("exit_psel", PSEL, 0);
            chk("exit_penable", PENABLE, 0);
         end else if (PSEL && PENABLE) begin
            acc++;
            chk("acc_paddr", PADDR, addr);
            chk("acc_pwrite", PWRITE, wr);
            chk("acc_pwdata", PWDATA, wd);
            if (nwait >= 0 && acc == nwait + 1) begin
               PREADY = 1'b1; PRDATA = prd;
            end
         end
      end
      PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
      if (!done) begin
         n_assert++; n_fail++;
         $display("FAIL resp_budget: actual=no_response required=response at %0t", $time);
      end
   endtask

   task automatic consume(input int hold, input logic [31:0] exp_rd, input logic exp_tmo);
      for (int i = 0; i < hold; i++) begin
         @(negedge PCLK);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_tmo", rsp_timeout, exp_tmo);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk("done_valid", rsp_valid, 0);
      chk("done_cmd_ready", cmd_ready, 1);
      chk("done_psel", PSEL, 0);
   endtask

   initial begin
      int          acc;
      logic        tmo;
      logic [31:0] rd;
      int          accepts;

      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
      repeat (3) @(negedge PCLK);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rdata", rsp_rdata, 0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("idle_cmd_ready", cmd_ready, 1);

      // write, zero wait states: PSEL +1, PENABLE +2, response +3
      issue(1'b1, 32'h0, 32'h6);
      chk("w0_psel", PSEL, 1);
      chk("w0_penable", PENABLE, 0);
      chk("w0_pwdata", PWDATA, 32'h6);
      wait_resp(0, 32'h0000_00FF, 1'b1, 32'h0, 32'h6, acc, tmo, rd);
      chk("w0_acc_cycles", acc, 1);
      chk("w0_rdata", rd, 0);
      chk("w0_tmo", tmo, 0);
      consume(0, 32'h0, 1'b0);

      // read with 3 wait states
      issue(1'b0, 32'h3, 32'h0);
      wait_resp(3, 32'h5D, 1'b0, 32'h3, 32'h0, acc, tmo, rd);
      chk("r3_acc_cycles", acc, 4);
      chk("r3_rdata", rd, 32'h5D);
      chk("r3_tmo", tmo, 0);
      consume(1, 32'h5D, 1'b0);

      // completer never ready: abort after TMO access cycles
      issue(1'b0, 32'h20, 32'h0);
      wait_resp(-1, 32'h0, 1'b0, 32'h20, 32'h0, acc, tmo, rd);
      chk("to_acc_cycles", acc, 4);
      chk("to_tmo", tmo, 1);
      chk("to_rdata", rd, 0);
      consume(0, 32'h0, 1'b1);

      // PREADY on the threshold cycle completes normally
      issue(1'b0, 32'h24, 32'h0);
      wait_resp(3, 32'hA5, 1'b0, 32'h24, 32'h0, acc, tmo, rd);
      chk("edge_acc_cycles", acc, 4);
      chk("edge_tmo", tmo, 0);
      chk("edge_rdata", rd, 32'hA5);
      consume(0, 32'hA5, 1'b0);

      // write with waits returns zero data even though PRDATA is nonzero
      issue(1'b1, 32'h0000_0ABC, 32'hCAFE_F00D);
      wait_resp(2, 32'hFFFF_FFFF, 1'b1, 32'h0000_0ABC, 32'hCAFE_F00D, acc, tmo, rd);
      chk("ww_acc_cycles", acc, 3);
      chk("ww_rdata", rd, 0);
      consume(0, 32'h0, 1'b0);

      // response stalled 5 cycles with a second command pending
      issue(1'b0, 32'h44, 32'h0);
      wait_resp(1, 32'h1234_5678, 1'b0, 32'h44, 32'h0, acc, tmo, rd);
      chk("st_rdata", rd, 32'h1234_5678);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'h77;
      consume(5, 32'h1234_5678, 1'b0);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      chk("st2_psel", PSEL, 1);
      chk("st2_paddr", PADDR, 32'h10);
      wait_resp(0, 32'h0, 1'b1, 32'h10, 32'h77, acc, tmo, rd);
      chk("st2_rdata", rd, 0);
      consume(0, 32'h0, 1'b0);

      // back-to-back: one acceptance every 4 cycles at best
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'h1;
      rsp_ready = 1'b1; PREADY = 1'b1; accepts = 0;
      for (int c = 0; c < 12; c++) begin
         if (cmd_ready) accepts++;
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      chk("b2b_accepts", accepts, 3);
      @(negedge PCLK);
      rsp_ready = 1'b0; PREADY = 1'b0;
      @(negedge PCLK);
      chk("b2b_idle", cmd_ready, 1);

      // reset pulse during ACCESS abandons the transfer
      issue(1'b0, 32'h88, 32'h0);
      @(negedge PCLK);
      chk("rr_penable", PENABLE, 1);
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("rr_psel", PSEL, 0);
      chk("rr_penable0", PENABLE, 0);
      chk("rr_rsp_valid", rsp_valid, 0);
      chk("rr_cmd_ready_in_rst", cmd_ready, 0);
      chk("rr_paddr", PADDR, 0);
      PRESET = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge PCLK);
         chk("rr_cmd_ready", cmd_ready, 1);
         chk("rr_no_rsp", rsp_valid, 0);
      end

      // recovery read
      issue(1'b0, 32'h8C, 32'h0);
      wait_resp(0, 32'h5A5A_0001, 1'b0, 32'h8C, 32'h0, acc, tmo, rd);
      chk("rec_rdata", rd, 32'h5A5A_0001);
      consume(0, 32'h5A5A_0001, 1'b0);

      repeat (2) @(negedge PCLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum ACCESS wait cycles before abort; 0 disables the timeout.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port PCLK, input, width 1: clock, all logic on the rising edge.
REQ-006 The block SHALL have port PRESET, input, width 1: synchronous, active-high reset.
REQ-007 The block SHALL have port cmd_valid, input, width 1: a command is offered.
REQ-008 The block SHALL have port cmd_ready, output, width 1: the block can accept a command.
REQ-009 The block SHALL have ports cmd_write (input, 1), cmd_addr (input, ADDR_W) and cmd_wdata (input, DATA_W): command fields.
REQ-010 The block SHALL have port rsp_valid, output, width 1: a response is available.
REQ-011 The block SHALL have port rsp_ready, input, width 1: the consumer accepts the response.
REQ-012 The block SHALL have ports rsp_rdata (output, DATA_W) and rsp_timeout (output, 1): read data and abort flag.
REQ-013 The block SHALL have APB requester outputs PADDR (ADDR_W), PSEL (1), PENABLE (1), PWRITE (1) and PWDATA (DATA_W).
REQ-014 The block SHALL have APB inputs PRDATA (DATA_W) and PREADY (1).

Function
REQ-015 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered except cmd_ready.
REQ-016 cmd_ready SHALL equal (state==IDLE) and not PRESET.
REQ-017 In IDLE, cmd_valid and cmd_ready high SHALL latch cmd_write, cmd_addr and cmd_wdata and move the FSM to SETUP.
REQ-018 In SETUP, PSEL SHALL be 1 and PENABLE 0, with PADDR, PWRITE and PWDATA driven from the latched command; the FSM SHALL move to ACCESS unconditionally after one cycle.
REQ-019 In ACCESS, PSEL and PENABLE SHALL both be 1, and PADDR, PWRITE and PWDATA SHALL stay identical to their SETUP values.
REQ-020 In ACCESS, PREADY sampled 1 SHALL capture rsp_rdata = PRDATA for a read, or 0 for a write, set rsp_timeout=0, and move to RESP.
REQ-021 On any exit from ACCESS, PSEL and PENABLE SHALL be 0 on the following cycle.
REQ-022 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-023 When the wait counter reaches TIMEOUT_CYCLES (nonzero), the block SHALL abort to RESP with rsp_timeout=1 and rsp_rdata=0.
REQ-024 If PREADY=1 in the same cycle the timeout threshold is reached, the block SHALL complete normally with rsp_timeout=0.
REQ-025 The wait counter SHALL be at least 16 bits wide and SHALL saturate without wrap-around.
REQ-026 In RESP, rsp_valid SHALL be 1, with rsp_rdata and rsp_timeout held stable until rsp_ready=1.
REQ-027 In RESP, rsp_ready=1 SHALL clear rsp_valid and move the FSM to IDLE on the next edge, so that back-to-back commands take at least 4 cycles each.
REQ-028 cmd_valid offered while the FSM is not in IDLE SHALL be ignored and SHALL not be latched.
REQ-029 In IDLE, PADDR, PWRITE and PWDATA SHALL hold their last values, and PSEL and PENABLE SHALL be 0.

Reset
REQ-030 PRESET=1 at a clock edge SHALL force state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0 and wait counter=0.
REQ-031 A reset asserted mid-transfer (SETUP, ACCESS or RESP) SHALL abandon that transfer with no response produced.
REQ-032 While PRESET=1, cmd_ready SHALL be 0.

Verification
REQ-033 Write addr 0x0, data 0x6, PREADY tied 1 -> PSEL at cycle +1, PENABLE at cycle +2, rsp_valid at cycle +3 with rsp_rdata=0 and rsp_timeout=0.
REQ-034 Read addr 0x3, slave inserts 3 wait states and then returns PRDATA=0x5D -> PADDR, PWRITE and PSEL stay stable through 4 ACCESS cycles, and rsp_rdata=0x5D.
REQ-035 TIMEOUT_CYCLES=4 with PREADY held 0 -> abort after 4 ACCESS cycles, rsp_timeout=1, rsp_rdata=0, and PSEL=0 on the next cycle.
REQ-036 TIMEOUT_CYCLES=4 with PREADY=1 on the 4th wait cycle and PRDATA=0xA5 -> rsp_timeout=0 and rsp_rdata=0xA5.
REQ-037 rsp_ready held 0 for 5 cycles with a second command pending -> rsp_valid and rsp_rdata stay held, cmd_ready=0, and the second command is accepted only after the response is consumed.
REQ-038 PRESET pulsed during ACCESS -> PSEL=0 and PENABLE=0 next cycle, no rsp_valid, and cmd_ready=1 once PRESET falls.
